alu_issue_stage: RTL and testbench

- Sequential issue/writeback stage wrapped around the team's 16-bit ALU (ops: AND, OR, ADD, SUB, less).
- Accepts one operation per valid/ready handshake and registers the operands.
- Drives the ALU control pins, runs set-less-than as a two-pass sequence, and returns a registered result plus N/Z/C/V flags over a second valid/ready handshake.
- Sits between the decode/register-read logic and the register-file writeback.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_flag_gen.sv | 40 ++++
 rtl/alu_issue_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/writeback stage: function codes, ALU op pins,
// flag bit positions and the sequencing state type.
package alu_pkg;

    localparam logic [3:0] FUNC_AND = 4'b0000;
    localparam logic [3:0] FUNC_OR  = 4'b0001;
    localparam logic [3:0] FUNC_ADD = 4'b0010;
    localparam logic [3:0] FUNC_SUB = 4'b0110;
    localparam logic [3:0] FUNC_SLT = 4'b0111;

    // bit 2 inverts B, bits 1:0 select the slice output
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_LESS = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SLT2 = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic func_legal(input logic [3:0] func);
        logic ok;
        ok = 1'b0;
        case (func)
            FUNC_AND, FUNC_OR, FUNC_ADD, FUNC_SUB, FUNC_SLT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // SLT's first pass is a plain subtraction
    function automatic logic [2:0] func_to_op(input logic [3:0] func);
        logic [2:0] op;
        op = OP_AND;
        case (func)
            FUNC_OR:            op = OP_OR;
            FUNC_ADD:           op = OP_ADD;
            FUNC_SUB, FUNC_SLT: op = OP_SUB;
            default:            op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Local N/Z/C/V generation for the pass that captures a result; also exposes the
// raw two's-complement overflow that the signed set-less-than decision needs.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_zero,
    output logic [3:0]       flags,
    output logic             ovf
);

    logic sub_like;
    logic arith;
    logic b_msb;

    always_comb begin
        sub_like = (func == FUNC_SUB) || (func == FUNC_SLT);
        arith    = (func == FUNC_ADD) || (func == FUNC_SUB);
        b_msb    = sub_like ? ~b[WIDTH-1] : b[WIDTH-1];
        // alu_result carries the adder sum on every arithmetic pass
        ovf      = (a[WIDTH-1] == b_msb) && (alu_result[WIDTH-1] != a[WIDTH-1]);

        flags         = '0;
        flags[FLAG_Z] = alu_zero;
        if (func != FUNC_SLT) begin
            flags[FLAG_N] = alu_result[WIDTH-1];
        end
        if (arith) begin
            flags[FLAG_C] = alu_cout;
            flags[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback wrapper around the 16-bit ALU: registers one operation, sequences
// the ALU control pins (two passes for set-less-than) and returns result plus flags.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// EXEC  | first ALU pass on the latched operands
// SLT2  | second SLT pass, less bit fed into slice 0
// DONE  | result valid, held until out_ready
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter bit SLT_SIGNED = 1'b1,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_less,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_set,
    input  logic             alu_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       func_q;
    logic             less_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             err_q;

    logic             accept;
    logic             legal_in;
    logic             is_slt;
    logic [2:0]       exec_op;
    logic [3:0]       flags_c;
    logic             ovf_c;
    logic             less_c;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign legal_in   = func_legal(in_func);
    assign is_slt     = (func_q == FUNC_SLT);
    assign exec_op    = func_to_op(func_q);

    assign out_valid  = (state == DONE);
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign out_err    = err_q;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .a          (a_q),
        .b          (b_q),
        .func       (func_q),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_zero   (alu_zero),
        .flags      (flags_c),
        .ovf        (ovf_c)
    );

    // unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1
    assign less_c = SLT_SIGNED ? (alu_set ^ ovf_c) : ~alu_cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_AND;
        alu_cin   = 1'b0;
        alu_less  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = legal_in ? EXEC : DONE;
                end
            end
            EXEC: begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = exec_op;
                alu_cin   = exec_op[2];
                state_nxt = is_slt ? SLT2 : DONE;
            end
            SLT2: begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = OP_LESS;
                alu_cin   = 1'b1;
                alu_less  = less_q;
                state_nxt = DONE;
            end
            DONE: begin
                if (accept) begin
                    state_nxt = legal_in ? EXEC : DONE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= FUNC_AND;
            less_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                func_q <= in_func;
                // illegal codes skip the ALU and complete with a zero result
                if (!legal_in) begin
                    result_q <= '0;
                    flags_q  <= '0;
                    err_q    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                if (is_slt) begin
                    less_q <= less_c;
                end else begin
                    result_q <= alu_result;
                    flags_q  <= flags_c;
                    err_q    <= 1'b0;
                end
            end
            if (state == SLT2) begin
                result_q <= alu_result;
                flags_q  <= flags_c;
                err_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: signed and unsigned SLT variants share stimulus, each
// with its own behavioural ALU; a per-cycle model checks handshakes and results.
module tb_alu_issue_stage;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a      = '0;
    logic [15:0] in_b      = '0;
    logic [3:0]  in_func   = '0;

    logic        in_ready_s, out_valid_s, out_err_s, alu_cin_s, alu_less_s;
    logic        alu_cout_s, alu_set_s, alu_zero_s;
    logic [15:0] out_result_s, alu_a_s, alu_b_s, alu_result_s;
    logic [3:0]  out_flags_s;
    logic [2:0]  alu_op_s;

    logic        in_ready_u, out_valid_u, out_err_u, alu_cin_u, alu_less_u;
    logic        alu_cout_u, alu_set_u, alu_zero_u;
    logic [15:0] out_result_u, alu_a_u, alu_b_u, alu_result_u;
    logic [3:0]  out_flags_u;
    logic [2:0]  alu_op_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // behavioural 16-bit ALU: {result, cout, set, zero}
    function automatic logic [18:0] alu_eval(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op, input logic cin, input logic less);
        logic [15:0] bb;
        logic [16:0] s;
        logic [15:0] r;
        bb = op[2] ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {16'b0, cin};
        case (op[1:0])
            2'b00:   r = a & bb;
            2'b01:   r = a | bb;
            2'b10:   r = s[15:0];
            default: r = {15'b0, less};
        endcase
        return {r, s[16], s[15], (r == 16'h0000)};
    endfunction

    assign {alu_result_s, alu_cout_s, alu_set_s, alu_zero_s} = alu_eval(alu_a_s, alu_b_s, alu_op_s, alu_cin_s, alu_less_s);
    assign {alu_result_u, alu_cout_u, alu_set_u, alu_zero_u} = alu_eval(alu_a_u, alu_b_u, alu_op_u, alu_cin_u, alu_less_u);

    alu_issue_stage #(.SLT_SIGNED(1'b1), .WIDTH(16)) u_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_func(in_func),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_result(out_result_s),
        .out_flags(out_flags_s), .out_err(out_err_s),
        .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_op(alu_op_s), .alu_cin(alu_cin_s),
        .alu_less(alu_less_s), .alu_result(alu_result_s), .alu_cout(alu_cout_s),
        .alu_set(alu_set_s), .alu_zero(alu_zero_s)
    );

    alu_issue_stage #(.SLT_SIGNED(1'b0), .WIDTH(16)) u_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_a(in_a), .in_b(in_b), .in_func(in_func),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_result(out_result_u),
        .out_flags(out_flags_u), .out_err(out_err_u),
        .alu_a(alu_a_u), .alu_b(alu_b_u), .alu_op(alu_op_u), .alu_cin(alu_cin_u),
        .alu_less(alu_less_u), .alu_result(alu_result_u), .alu_cout(alu_cout_u),
        .alu_set(alu_set_u), .alu_zero(alu_zero_u)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // architectural result of one operation, straight from the function definitions
    task automatic model_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                            input bit signed_slt, output logic [15:0] r, output logic [3:0] fl,
                            output logic e, output int lat);
        int sa;
        int sb;
        int sr;
        logic [16:0] w;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        e   = 1'b0;
        fl  = 4'h0;
        r   = 16'h0000;
        lat = 2;
        case (f)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: begin
                w     = {1'b0, a} + {1'b0, b};
                r     = w[15:0];
                sr    = sa + sb;
                fl[1] = w[16];
                fl[0] = (sr > 32767) || (sr < -32768);
            end
            4'h6: begin
                r     = a - b;
                sr    = sa - sb;
                fl[1] = (a >= b);
                fl[0] = (sr > 32767) || (sr < -32768);
            end
            4'h7: begin
                r   = signed_slt ? 16'(sa < sb) : 16'(a < b);
                lat = 3;
            end
            default: begin
                e   = 1'b1;
                lat = 1;
            end
        endcase
        if (!e) begin
            fl[2] = (r == 16'h0000);
            if (f != 4'h7) fl[3] = r[15];
        end
    endtask

    // mode: 0 idle, 1 computing, 2 result presented
    int          mode = 0;
    int          cnt  = 0;
    int          lat_s, lat_u;
    logic [15:0] er_s, er_u;
    logic [3:0]  ef_s, ef_u;
    logic        ee_s, ee_u;
    logic        acc;

    always @(negedge clk) begin
        cmp("m_valid_s", 64'(out_valid_s), 64'(mode == 2));
        cmp("m_valid_u", 64'(out_valid_u), 64'(mode == 2));
        cmp("m_ready_s", 64'(in_ready_s), 64'((mode == 0) || (mode == 2 && out_ready)));
        cmp("m_ready_u", 64'(in_ready_u), 64'((mode == 0) || (mode == 2 && out_ready)));
        if (mode == 2) begin
            cmp("m_result_s", 64'(out_result_s), 64'(er_s));
            cmp("m_flags_s",  64'(out_flags_s),  64'(ef_s));
            cmp("m_err_s",    64'(out_err_s),    64'(ee_s));
            cmp("m_result_u", 64'(out_result_u), 64'(er_u));
            cmp("m_flags_u",  64'(out_flags_u),  64'(ef_u));
            cmp("m_err_u",    64'(out_err_u),    64'(ee_u));
        end
        if (mode != 1) begin
            cmp("m_alu_idle_s", 64'(alu_a_s == 0 && alu_b_s == 0 && alu_op_s == 0 && !alu_cin_s && !alu_less_s), 64'd1);
        end
        if (reset) begin
            mode = 0;
        end else begin
            acc = in_valid && ((mode == 0) || (mode == 2 && out_ready));
            if (mode == 2 && out_ready) begin
                mode = 0;
            end else if (mode == 1) begin
                cnt--;
                if (cnt == 0) mode = 2;
            end
            if (acc) begin
                model_op(in_func, in_a, in_b, 1'b1, er_s, ef_s, ee_s, lat_s);
                model_op(in_func, in_a, in_b, 1'b0, er_u, ef_u, ee_u, lat_u);
                if (lat_s == 1) begin
                    mode = 2;
                end else begin
                    mode = 1;
                    cnt  = lat_s - 1;
                end
            end
        end
    end

    task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_func  = f;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_s) cmp("send_timeout", 64'(in_ready_s), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid_s && lat < 20);
    endtask

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a, b, rs, ru;
        logic [3:0]  fs, fu;
        int          lat;
    } vec_t;

    vec_t vecs [8] = '{
        '{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 4'b1001, 4'b1001, 2},
        '{4'h6, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0110, 4'b0110, 2},
        '{4'h0, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h00F0, 4'b0000, 4'b0000, 2},
        '{4'h1, 16'hF000, 16'h000F, 16'hF00F, 16'hF00F, 4'b1000, 4'b1000, 2},
        '{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b0110, 4'b0110, 2},
        '{4'h7, 16'h8000, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 4'b0100, 3},
        '{4'h7, 16'h7FFF, 16'h8000, 16'h0000, 16'h0001, 4'b0100, 4'b0000, 3},
        '{4'h6, 16'h0001, 16'h0002, 16'hFFFF, 16'hFFFF, 4'b1000, 4'b1000, 2}
    };

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cmp("rst_in_ready",  64'(in_ready_s),   64'd1);
        cmp("rst_out_valid", 64'(out_valid_s),  64'd0);
        cmp("rst_result",    64'(out_result_s), 64'd0);
        cmp("rst_flags",     64'(out_flags_s),  64'd0);
        cmp("rst_err",       64'(out_err_s),    64'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            send(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_valid(lat);
            cmp($sformatf("v%0d_latency", i),  64'(lat),          64'(vecs[i].lat));
            cmp($sformatf("v%0d_result_s", i), 64'(out_result_s), 64'(vecs[i].rs));
            cmp($sformatf("v%0d_flags_s", i),  64'(out_flags_s),  64'(vecs[i].fs));
            cmp($sformatf("v%0d_result_u", i), 64'(out_result_u), 64'(vecs[i].ru));
            cmp($sformatf("v%0d_flags_u", i),  64'(out_flags_u),  64'(vecs[i].fu));
            @(posedge clk);
            #1;
        end

        out_ready = 1'b0;
        send(4'h2, 16'h1234, 16'h1111);
        wait_valid(lat);
        cmp("bp_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_func  = 4'h6;
        in_a     = 16'h0005;
        in_b     = 16'h0005;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cmp("bp_hold_result", 64'(out_result_s), 64'h2345);
            cmp("bp_in_ready",    64'(in_ready_s),   64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        cmp("bp_same_cycle_accept", 64'(in_ready_s), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        cmp("bp_next_latency", 64'(lat),          64'd2);
        cmp("bp_next_result",  64'(out_result_s), 64'h0000);
        cmp("bp_next_flags",   64'(out_flags_s),  64'b0110);
        @(posedge clk);
        #1;

        send(4'hF, 16'hAAAA, 16'h5555);
        wait_valid(lat);
        cmp("ill_latency", 64'(lat),          64'd1);
        cmp("ill_result",  64'(out_result_s), 64'h0000);
        cmp("ill_flags",   64'(out_flags_s),  64'h0);
        cmp("ill_err",     64'(out_err_s),    64'd1);
        @(posedge clk);
        #1;

        send(4'h7, 16'h8000, 16'h0001);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cmp("mid_rst_in_ready", 64'(in_ready_s),   64'd1);
        cmp("mid_rst_valid",    64'(out_valid_s),  64'd0);
        cmp("mid_rst_result",   64'(out_result_s), 64'd0);
        cmp("mid_rst_flags",    64'(out_flags_s),  64'd0);
        cmp("mid_rst_err",      64'(out_err_s),    64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmp("mid_rst_no_valid", 64'(out_valid_s), 64'd0);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
